// File: rtl/pipereg_stage.sv
// pipereg_stage: pipeline stage register carrying result, read data and a
// destination index between two stages, with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a post-reset clearing interval.
// All state updates happen on the falling edge of clk.
module pipereg_stage #(
    parameter int WIDTH        = 32,
    parameter int RD_W         = 5,
    parameter int CLEAR_CYCLES = 1,
    parameter int SKID         = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [WIDTH-1:0] in_rdata,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_rdata,
    output logic [RD_W-1:0]  out_rd,
    output logic             clearing
);

    localparam int CNT_W = (CLEAR_CYCLES > 0) ? $clog2(CLEAR_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CLEAR_MAX = CNT_W'(CLEAR_CYCLES);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        EMPTY = 2'd1,
        ONE   = 2'd2,
        TWO   = 2'd3
    } state_t;

    // With no clearing interval the stage comes out of reset already empty,
    // so in_ready is allowed to rise as soon as reset is released.
    localparam state_t RESET_STATE    = (CLEAR_CYCLES == 0) ? EMPTY : CLEAR;
    localparam logic   IN_READY_RESET = (CLEAR_CYCLES == 0);

    state_t             r_state;
    state_t             w_stateNext;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic               r_inReady;
    logic [WIDTH-1:0]   r_headResult;
    logic [WIDTH-1:0]   r_headRdata;
    logic [RD_W-1:0]    r_headRd;
    logic [WIDTH-1:0]   r_skidResult;
    logic [WIDTH-1:0]   r_skidRdata;
    logic [RD_W-1:0]    r_skidRd;
    logic               w_outValid;
    logic               w_clearing;
    logic               w_inReady;
    logic               w_push;
    logic               w_pop;
    logic               w_loadHead;
    logic               w_headFromSkid;
    logic               w_loadSkid;

    assign w_outValid = (r_state == ONE) || (r_state == TWO);
    assign w_clearing = (r_state == CLEAR);
    assign w_push     = in_valid & w_inReady;
    assign w_pop      = w_outValid & out_ready;

    // Select the ready source: registered in skid mode, combinational otherwise.
    always_comb begin
        w_inReady = 1'b0;
        if (SKID != 0) begin
            w_inReady = r_inReady & ~reset;
        end else begin
            w_inReady = ~reset & ~w_clearing & (~w_outValid | out_ready);
        end
    end

    // Next-state and datapath load decisions; flush outranks push and pop.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_loadHead     = 1'b0;
        w_headFromSkid = 1'b0;
        w_loadSkid     = 1'b0;
        if (r_state == CLEAR) begin
            if (r_cnt != CLEAR_MAX) begin
                w_cntNext = r_cnt + CNT_W'(1);
            end
            if (w_cntNext == CLEAR_MAX) begin
                w_stateNext = EMPTY;
            end
        end else if (flush) begin
            w_stateNext = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_loadHead  = 1'b1;
                        w_stateNext = ONE;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_loadHead = 1'b1;
                    end else if (w_push && (SKID != 0)) begin
                        w_loadSkid  = 1'b1;
                        w_stateNext = TWO;
                    end else if (w_pop) begin
                        w_stateNext = EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_headFromSkid = 1'b1;
                        w_stateNext    = ONE;
                    end
                end
                default: begin
                    w_stateNext = r_state;
                end
            endcase
        end
    end

    // State, clear counter and registered ready, all on the falling edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RESET_STATE;
            r_cnt     <= '0;
            r_inReady <= IN_READY_RESET;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_inReady <= (w_stateNext == EMPTY) || (w_stateNext == ONE);
        end
    end

    // Head entry: loaded from upstream or promoted from the skid slot.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_headResult <= '0;
            r_headRdata  <= '0;
            r_headRd     <= '0;
        end else if (w_loadHead) begin
            r_headResult <= in_result;
            r_headRdata  <= in_rdata;
            r_headRd     <= in_rd;
        end else if (w_headFromSkid) begin
            r_headResult <= r_skidResult;
            r_headRdata  <= r_skidRdata;
            r_headRd     <= r_skidRd;
        end
    end

    // Skid slot catches the entry that arrives while the head is stalled.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_skidResult <= '0;
            r_skidRdata  <= '0;
            r_skidRd     <= '0;
        end else if (w_loadSkid) begin
            r_skidResult <= in_result;
            r_skidRdata  <= in_rdata;
            r_skidRd     <= in_rd;
        end
    end

    // Bubbles are presented as zero payload so they look like nop writes to x0.
    always_comb begin
        out_result = '0;
        out_rdata  = '0;
        out_rd     = '0;
        if (w_outValid) begin
            out_result = r_headResult;
            out_rdata  = r_headRdata;
            out_rd     = r_headRd;
        end
    end

    assign out_valid = w_outValid;
    assign in_ready  = w_inReady;
    assign clearing  = w_clearing;

endmodule

// File: doc/pipereg_stage.md
# pipereg_stage

Parametrised pipeline stage register for the e5rv32 core, the general-purpose successor to the fixed EX/MEM register. It carries a result word, a read-data word and a destination register index between two pipeline stages. It adds a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush, and a configurable post-reset clearing interval. One instance sits between each pair of adjacent stages (ID/EX, EX/MEM, MEM/WB).

## Interface
- WIDTH, 32: width of the result and read-data payload words.
- RD_W, 5: width of the destination register index.
- CLEAR_CYCLES, 1: number of falling clk edges after reset release during which the stage accepts nothing; 0 means no clearing interval.
- SKID, 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_result  in  WIDTH  upstream result.
- in_rdata  in  WIDTH  upstream read data.
- in_rd  in  RD_W  upstream destination index.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_result  out  WIDTH  head result.
- out_rdata  out  WIDTH  head read data.
- out_rd  out  RD_W  head destination index.
- clearing  out  1  high during the post-reset clearing interval.

## Operation
- States: CLEAR, EMPTY, ONE, TWO. TWO exists only when SKID=1.
- Reset asserted: the state goes to CLEAR immediately, or to EMPTY if CLEAR_CYCLES=0.
  - All payload outputs are 0, out_valid is 0, in_ready is 0.
  - clearing is 1 if CLEAR_CYCLES>0, otherwise 0.
  - The clear counter loads 0.
- CLEAR: each falling edge increments the counter. On the edge where the counter reaches CLEAR_CYCLES, the state goes to EMPTY and clearing drops.
  - in_ready is 0 and out_valid is 0 throughout CLEAR.
  - flush, in_valid and out_ready are ignored in CLEAR.
- Transfers (outside CLEAR) occur on the falling edge:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: push goes to ONE.
  - ONE: push without pop goes to TWO (SKID=1). Push with pop stays in ONE with the new head. Pop without push goes to EMPTY.
  - TWO: pop moves the skid entry to the head and goes to ONE. No push is possible in TWO.
- Ordering is strictly FIFO; the skid entry never overtakes the head.
- When the stage is EMPTY (out_valid=0), out_result, out_rdata and out_rd are 0. Bubbles read as nop writes to x0.
- in_ready:
  - SKID=1: a registered value, 1 in EMPTY and ONE, 0 in TWO and CLEAR.
  - SKID=0: in_ready = ~clearing & (~out_valid | out_ready).
- flush=1 outside CLEAR:
  - The next edge empties the stage and zeroes the payload outputs.
  - A push presented on the flush edge is dropped.
  - flush has priority over push and pop.
- Reset asserted mid-operation: all entries are discarded asynchronously and the clearing interval restarts after release.

## Timing
- Latency: an entry pushed on falling edge N appears on the out_* ports after edge N.
  - Minimum in-to-out latency is one edge.
  - No combinational path from in_* to out_*.
- Throughput: one entry per cycle when out_ready is held high.
- SKID=1: in_ready deasserts only after the edge on which the stage enters TWO. An upstream driver that sampled in_ready=1 always has its entry accepted, with no loss.
- SKID=0: out_ready→in_ready is a combinational path. This mode is for timing-relaxed stages only.
- Reset release to first possible push: CLEAR_CYCLES falling edges, plus the edge on which the push occurs.
- Counter width: $clog2(CLEAR_CYCLES+1) bits, minimum 1. It saturates at CLEAR_CYCLES and never wraps.

## Test plan
- Reset and clear interval (CLEAR_CYCLES=2):
  - Stimulus: assert reset, release, hold in_valid=1.
  - Required: all outputs 0, in_ready=0 and clearing=1 for 2 falling edges. Then in_ready=1 and the first entry is accepted on edge 3.
- Streaming (SKID=1, out_ready=1):
  - Stimulus: push result 0x11,0x22,0x33 with rd=1,2,3.
  - Required: these appear on consecutive edges at one-edge latency, with no bubbles.
- Backpressure (SKID=1):
  - Stimulus: push A=0xAAAA0000, then B=0xBBBB0000 with out_ready=0.
  - Required: state TWO, in_ready=0, out_result=0xAAAA0000. After raising out_ready: A, then B, then out_valid=0 with payload outputs 0.
- Flush priority:
  - Stimulus: in TWO, assert flush and in_valid with result 0xDEAD on the same edge.
  - Required: next edge out_valid=0, payload outputs 0, 0xDEAD never appears, in_ready=1.
- Reset mid-stream:
  - Stimulus: assert reset between edges while in ONE.
  - Required: out_valid and the payload outputs drop to 0 immediately, without waiting for a clock edge. The clear interval restarts on release.
- SKID=0 mode:
  - Stimulus: out_ready=0 with one entry held.
  - Required: in_ready=0. Raising out_ready raises in_ready in the same cycle, and a simultaneous push and pop keeps out_valid=1 with the new payload.
